// File: rtl/muxscan_pkg.sv
// muxscan_pkg: shared types and constants for the muxscan_ctl scan sequencer.
//   state_t      - scan FSM states
//   CH_W/NUM_CH  - selector channel index width / channel count
//   CNT_W        - settle counter width
//   SETTLE_MIN/MAX - legal settle range (larger values are clamped)
//   RETRY_MAX    - mismatch limit for the debounce option
package muxscan_pkg;

    typedef enum logic [2:0] {IDLE, SEL, WAIT, SAMP, DONE} state_t;

    localparam int CH_W       = 3;
    localparam int NUM_CH     = 1 << CH_W;
    localparam int CNT_W      = 4;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;
    localparam int RETRY_MAX  = 3;

endpackage

// File: rtl/muxscan_next.sv
// muxscan_next: combinational priority finder.
//   mask - channel skip mask (1 = skip)
//   from - first candidate index; may equal NUM_CH, which means "none left"
//   idx  - lowest unmasked index >= from (0 when none)
//   none - no unmasked channel at or above from
module muxscan_next
    import muxscan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W:0]     from,
    output logic [CH_W-1:0]   idx,
    output logic              none
);

    // Scan downward so the last hit, the lowest index, wins.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!mask[i] && (i >= int'(from))) begin
                idx  = CH_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/muxscan_ctl.sv
// muxscan_ctl: scan sequencer for an external 8-to-1 data selector.
// Walks all unmasked channels, waits SETTLE cycles per channel, samples y
// and publishes an 8-bit snapshot with per-bit change flags.
//   clk, clr_n      - clock, async active-low clear
//   start, cont     - single-cycle scan request / continuous mode
//   mask[7:0]       - 1 = skip channel (bit keeps its previous value)
//   a, b, c, s      - selector address (c = MSB) and active-low strobe
//   y               - selector output
//   data, chg, vld  - snapshot, changed bits, one-cycle update pulse
//   busy            - scan in progress
//   err             - sticky debounce failure (MUXSCAN_DEBOUNCE_EN only)
// Optional feature macro: MUXSCAN_DEBOUNCE_EN (double sampling with retry).
module muxscan_ctl
    import muxscan_pkg::*;
#(
    parameter int SETTLE       = 2,
    parameter bit CONT_DEFAULT = 1'b0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              cont,
    input  logic [NUM_CH-1:0] mask,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              s,
    input  logic              y,
    output logic [NUM_CH-1:0] data,
    output logic [NUM_CH-1:0] chg,
    output logic              vld,
`ifdef MUXSCAN_DEBOUNCE_EN
    output logic              err,
`endif
    output logic              busy
);

    localparam int SETTLE_C = (SETTLE < SETTLE_MIN) ? SETTLE_MIN :
                              (SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_C - 1);

    state_t            state, state_n;
    logic [CH_W-1:0]   ch;
    logic [CNT_W-1:0]  cnt;
    logic              cont_q;
    logic [NUM_CH-1:0] mask_q, shadow;
    logic              go, empty_pulse, adv;

    logic [NUM_CH-1:0] f_mask;
    logic [CH_W:0]     f_from;
    logic [CH_W-1:0]   f_idx;
    logic              f_none;

`ifdef MUXSCAN_DEBOUNCE_EN
    logic       phase, first;
    logic [1:0] retry;
`endif

    // One finder serves both the first-channel load (from 0, live mask)
    // and the advance step (from ch+1, mask captured at scan start).
    muxscan_next u_next (
        .mask (f_mask),
        .from (f_from),
        .idx  (f_idx),
        .none (f_none)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n     = state;
        go          = 1'b0;
        empty_pulse = 1'b0;
        adv         = 1'b0;
        f_mask      = (state == SAMP) ? mask_q : mask;
        f_from      = (state == SAMP) ? ((CH_W+1)'(ch) + (CH_W+1)'(1)) : '0;
        case (state)
            IDLE: if (start || cont_q) begin
                if (!f_none) begin
                    go      = 1'b1;
                    state_n = SEL;
                end else if (start || !vld) begin
                    // all masked: report an empty scan; in continuous mode
                    // the !vld gate spaces the pulses one idle cycle apart
                    empty_pulse = 1'b1;
                end
            end
            SEL:  state_n = WAIT;
            WAIT: if (cnt == '0) state_n = SAMP;
            SAMP: begin
`ifdef MUXSCAN_DEBOUNCE_EN
                if (!phase)                                           state_n = WAIT;
                else if ((y == first) || (retry == 2'(RETRY_MAX - 1))) adv     = 1'b1;
                else                                                  state_n = WAIT;
`else
                adv = 1'b1;
`endif
                if (adv) state_n = f_none ? DONE : SEL;
            end
            DONE: begin
                // continuous mode chains straight into the next scan
                if (cont_q && !f_none) begin
                    go      = 1'b1;
                    state_n = SEL;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ch        <= '0;
            cnt       <= '0;
            cont_q    <= CONT_DEFAULT;
            mask_q    <= '0;
            shadow    <= '0;
            {c, b, a} <= '0;
            s         <= 1'b1;
            data      <= '0;
            chg       <= '0;
            vld       <= 1'b0;
            busy      <= 1'b0;
`ifdef MUXSCAN_DEBOUNCE_EN
            phase     <= 1'b0;
            first     <= 1'b0;
            retry     <= '0;
            err       <= 1'b0;
`endif
        end else begin
            cont_q <= cont;
            vld    <= 1'b0;
            busy   <= (state_n != IDLE);
            if (go) begin
                ch     <= f_idx;
                mask_q <= mask;
            end
`ifdef MUXSCAN_DEBOUNCE_EN
            if (start && state == IDLE) err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // preload so masked channels keep their old value
                    if (go) shadow <= data;
                    if (empty_pulse) begin
                        vld <= 1'b1;
                        chg <= '0;
                    end
                end
                SEL: begin
                    {c, b, a} <= ch;
                    s         <= 1'b0;
                    cnt       <= RELOAD;
`ifdef MUXSCAN_DEBOUNCE_EN
                    phase     <= 1'b0;
                    retry     <= '0;
`endif
                end
                WAIT: if (cnt != '0) cnt <= cnt - CNT_W'(1);
                SAMP: begin
`ifdef MUXSCAN_DEBOUNCE_EN
                    if (!phase) begin
                        first <= y;
                        phase <= 1'b1;
                        cnt   <= RELOAD;
                    end else if (!adv) begin
                        retry <= retry + 2'd1;
                        phase <= 1'b0;
                        cnt   <= RELOAD;
                    end else if (y != first) begin
                        err <= 1'b1;
                    end
`endif
                    if (adv) begin
                        shadow[ch] <= y;
                        if (!f_none) ch <= f_idx;
                    end
                end
                DONE: begin
                    // a chained restart reuses shadow, which now equals data
                    s    <= 1'b1;
                    data <= shadow;
                    chg  <= shadow ^ data;
                    vld  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muxscan_ctl.sv
// tb_muxscan_ctl: directed, table-driven bench for muxscan_ctl (SETTLE=2).
// Models the LS151 selector (y forced low while s is high).
module tb_muxscan_ctl;

    logic       clk = 1'b0;
    logic       clr_n, start, cont, y;
    logic [7:0] mask, pat, data, chg;
    logic       a, b, c, s, vld, busy;
    logic [2:0] sel;
    logic       tog, tgl;
`ifdef MUXSCAN_DEBOUNCE_EN
    logic       err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    initial tgl = 1'b0;
    always @(posedge clk) tgl <= ~tgl;

    assign sel = {c, b, a};
    assign y   = s ? 1'b0 : ((tog && sel == 3'd3) ? tgl : pat[sel]);

    muxscan_ctl #(.SETTLE(2), .CONT_DEFAULT(1'b0)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start),
        .cont  (cont),
        .mask  (mask),
        .a     (a),
        .b     (b),
        .c     (c),
        .s     (s),
        .y     (y),
        .data  (data),
        .chg   (chg),
        .vld   (vld),
`ifdef MUXSCAN_DEBOUNCE_EN
        .err   (err),
`endif
        .busy  (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Pulse start, then observe at each falling edge until vld.
    // lat = edges from acceptance (edge 0) to the edge that raised vld.
    task automatic do_scan(input logic [7:0] m, input logic [7:0] p, output int lat,
                           output logic [7:0] seen, output bit ord, output int slow);
        int last;
        last = -1; seen = '0; ord = 1'b1; slow = 0; lat = -1;
        @(negedge clk); mask = m; pat = p; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (vld) begin lat = k; break; end
            if (!s) begin
                slow++;
                seen[sel] = 1'b1;
                if (int'(sel) != last) begin
                    if (int'(sel) < last) ord = 1'b0;
                    last = int'(sel);
                end
            end
            @(negedge clk);
        end
    endtask

    // Edges until the next vld, -1 on timeout.
    task automatic wait_vld(input int limit, output int gap);
        gap = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (vld) begin gap = k; break; end
        end
    endtask

    typedef struct {
        logic [7:0] mask, pat, exp_data, exp_chg, exp_seen;
        int         exp_lat;
    } vec_t;

    vec_t       vt[7];
    int         lat, slow, gap, nv;
    logic [7:0] seen;
    bit         ord;

    initial begin
        vt[0] = '{8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hFF, 33};
        vt[1] = '{8'h00, 8'hA4, 8'hA4, 8'h01, 8'hFF, 33};
        vt[2] = '{8'h00, 8'hA5, 8'hA5, 8'h01, 8'hFF, 33};
        vt[3] = '{8'hF0, 8'h0F, 8'hAF, 8'h0A, 8'h0F, 17};
        vt[4] = '{8'h55, 8'h00, 8'h05, 8'hAA, 8'hAA, 17};
        vt[5] = '{8'h7F, 8'h80, 8'h85, 8'h80, 8'h80, 5};
        vt[6] = '{8'hFE, 8'h00, 8'h84, 8'h01, 8'h01, 5};

        clr_n = 1'b0; start = 1'b0; cont = 1'b0; mask = '0; pat = '0; tog = 1'b0;
        #12;
        chk("rst_data", data, 8'h00);
        chk("rst_chg",  chg,  8'h00);
        chk("rst_vld",  vld,  1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_s",    s,    1'b1);
        chk("rst_sel",  sel,  3'd0);
        @(negedge clk); clr_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_scan(vt[i].mask, vt[i].pat, lat, seen, ord, slow);
            chk($sformatf("v%0d_lat", i),  lat,  vt[i].exp_lat);
            chk($sformatf("v%0d_data", i), data, vt[i].exp_data);
            chk($sformatf("v%0d_chg", i),  chg,  vt[i].exp_chg);
            chk($sformatf("v%0d_seen", i), seen, vt[i].exp_seen);
            chk($sformatf("v%0d_ord", i),  ord,  1'b1);
            chk($sformatf("v%0d_slow", i), slow, vt[i].exp_lat - 1);
            chk($sformatf("v%0d_busy", i), busy, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_vld1", i), vld, 1'b0);
        end

        // continuous mode: steady 33-cycle period
        @(negedge clk); mask = 8'h00; pat = 8'h3C; cont = 1'b1;
        wait_vld(100, gap);
        chk("cont_first", gap != -1, 1'b1);
        chk("cont_data0", data, 8'h3C);
        chk("cont_chg0",  chg,  8'hB8);
        wait_vld(100, gap);
        chk("cont_gap1", gap,  33);
        chk("cont_chg1", chg,  8'h00);
        chk("cont_busy", busy, 1'b1);
        wait_vld(100, gap);
        chk("cont_gap2", gap, 33);

        // drop cont mid-scan: exactly one more vld, then idle
        repeat (10) @(negedge clk);
        cont = 1'b0;
        nv = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (vld) nv++;
        end
        chk("drop_nvld", nv,   1);
        chk("drop_busy", busy, 1'b0);

        // all masked with cont: empty report every 2 cycles
        @(negedge clk); mask = 8'hFF; cont = 1'b1;
        wait_vld(20, gap);
        chk("ff_first", gap != -1, 1'b1);
        chk("ff_chg",   chg,  8'h00);
        chk("ff_data",  data, 8'h3C);
        wait_vld(20, gap);
        chk("ff_gap",  gap,  2);
        chk("ff_busy", busy, 1'b0);
        cont = 1'b0;
        repeat (4) @(negedge clk);
        mask = 8'h00;

        // async clear mid-scan
        @(negedge clk); pat = 8'hC3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        chk("clr_busy_pre", busy, 1'b1);
        #2 clr_n = 1'b0;
        #1;
        chk("clr_s",    s,    1'b1);
        chk("clr_busy", busy, 1'b0);
        chk("clr_sel",  sel,  3'd0);
        chk("clr_data", data, 8'h00);
        chk("clr_vld",  vld,  1'b0);
        @(negedge clk); clr_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (vld) nv++;
        end
        chk("clr_novld", nv, 0);
        do_scan(8'h00, 8'h5A, lat, seen, ord, slow);
        chk("post_lat",  lat,  33);
        chk("post_data", data, 8'h5A);
        chk("post_chg",  chg,  8'h5A);

`ifdef MUXSCAN_DEBOUNCE_EN
        // y on channel 3 never settles: retries exhaust and err sticks
        tog = 1'b1;
        do_scan(8'hF7, 8'h00, lat, seen, ord, slow);
        chk("db_lat_ok", lat != -1, 1'b1);
        chk("db_err",    err, 1'b1);
        tog = 1'b0;
        @(negedge clk);
        do_scan(8'hF7, 8'h08, lat, seen, ord, slow);
        chk("db_err_clr", err,     1'b0);
        chk("db_bit3",    data[3], 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/muxscan_ctl.md
Name: muxscan_ctl

Overview:
- Synchronous scan sequencer for an external 8-to-1 data selector (LS151-class: select c/b/a, active-low strobe s, true output y).
- Walks the selector through all unmasked channels, waits a programmable settle time per channel, samples y and assembles an 8-bit snapshot.
- Reports the snapshot plus per-bit change flags to the host logic.
- Sits between the selector device model and a board-level controller; replaces hand-wired counter/latch glue.

Parameters:
- SETTLE, 2: wait cycles after select/strobe change before sampling (range 1..15); sizes for selector tPD max vs. clk period.
- CONT_DEFAULT, 0: reset value of the continuous-mode latch.

Ports:
- clk, input, 1: rising-edge clock.
- clr_n, input, 1: asynchronous active-low clear.
- start, input, 1: single-cycle scan request.
- cont, input, 1: continuous mode; when high, a new scan begins right after DONE.
- mask, input, 8: bit k = 1 skips channel k; that snapshot bit holds its previous value.
- a, output, 1: selector LSB.
- b, output, 1: selector middle bit.
- c, output, 1: selector MSB.
- s, output, 1: selector strobe, active low (0 = enabled).
- y, input, 1: selector true output.
- data, output, 8: last completed snapshot; bit k = channel k.
- chg, output, 8: bits that differ from the previous snapshot; valid with vld.
- vld, output, 1: one-cycle pulse when data/chg update.
- busy, output, 1: high from scan acceptance through DONE.

Behaviour:
- Reset (clr_n low, async): state IDLE; {c,b,a}=000; s=1; data=00; chg=00; vld=0; busy=0; settle count=0; internal cont latch=CONT_DEFAULT.
- Outputs are registered; no combinational path from y to any output.
- States:
  - IDLE: wait for start=1 or cont=1. If mask=FF, pulse vld with chg=00, data unchanged, and stay in IDLE. Otherwise load ch = lowest unmasked index and go to SEL.
  - SEL: drive {c,b,a}=ch, s=0, count=SETTLE-1, go to WAIT.
  - WAIT: decrement count; at 0 go to SAMP.
  - SAMP: shadow[ch] <= y. If a higher unmasked channel exists, set ch to it and go to SEL; otherwise go to DONE.
  - DONE: s=1; data <= shadow; chg <= shadow ^ old data; vld=1 for this cycle; go to IDLE.
- busy=1 in SEL/WAIT/SAMP/DONE.
- Latency: per-channel cost is SETTLE+2 cycles. A full 8-channel scan with SETTLE=2 has start-to-vld = 8*4 + 1 = 33 cycles.
- The shadow register preloads from data at scan start, so masked bits keep their old value and report chg=0.
- start while busy is ignored (no queuing). start and cont together behave as start.
- cont dropped mid-scan: the current scan finishes; no new scan begins.
- mask is sampled once at scan start; changes mid-scan take effect on the next scan.
- ch wraps 7→0 only across scans, never within one.
- clr_n asserted mid-scan: immediate return to reset values. The partial shadow is discarded and no vld is produced.
- s stays 0 through consecutive channels of one scan; only {c,b,a} changes.

Optional Feature:
- Macro: MUXSCAN_DEBOUNCE_EN.
- Defined: SAMP samples twice, SETTLE cycles apart. Unequal samples restart that channel's WAIT. After 3 mismatches the bit takes the last sample and a sticky output err (1 bit, cleared by clr_n or start) is set.
- Not defined: single sample; err port absent.

Decomposition:
- Package muxscan_pkg:
  - state enum (IDLE, SEL, WAIT, SAMP, DONE);
  - channel index width constant (3);
  - SETTLE range limits;
  - retry limit constant (3).
- One sub-module, muxscan_next: combinational priority finder returning the lowest unmasked index ≥ n and a none-left flag. It is used for both the first-channel load and the advance step.

Test Plan:
- Reset, full scan: clr_n pulse; mask=00; selector inputs 0xA5; start → vld at cycle 33; data=A5; chg=A5; {c,b,a} sequence 0..7; s low for 32 cycles.
- Change detection: second scan with inputs 0xA4 → data=A4, chg=01.
- Masking: mask=F0, inputs 0x0F, prior data=A5 → vld after 4*4+1 = 17 cycles; data=AF; chg=0A; channels 4..7 never selected.
- Continuous mode: cont held → vld every 33 cycles. Drop cont mid-scan → exactly one more vld, then IDLE with busy=0. mask=FF with cont → vld every 2 cycles, chg=00.
- Async clear: clr_n low at cycle 10 of a scan → outputs at reset values the same cycle; no vld; next start scans cleanly.
- Debounce (MUXSCAN_DEBOUNCE_EN): y toggles on channel 3 for 2 sample pairs, then stable 1 → bit3=1, err=0. Y toggling indefinitely → err=1 after 3 retries.
